// File: rtl/tof_serial_cfg_loader.sv
// 3-wire (SCLK/SDIN/LE) power-up configuration loader for an external PLL, with lock wait and retry.
// Optional macro TOF_SERIAL_CFG_RELOCK_EN: restart the sequence when lock is lost after DONE.
module tof_serial_cfg_loader #(
    parameter int    WORD_BITS    = 24,
    parameter int    NUM_WORDS    = 3,
    parameter int    CLK_DIV      = 32,
    parameter int    WAIT_TICKS   = 94000,
    parameter int    LOCK_TIMEOUT = 65535,
    parameter int    MAX_RETRY    = 3,
    parameter string SIM_SPDUP    = "FALSE",
    localparam int   RW           = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           init_i,
    input  logic                           init_skip_i,
    input  logic [NUM_WORDS*WORD_BITS-1:0] words_i,
    input  logic [NUM_WORDS-1:0]           wait_mask_i,
    input  logic                           pll_lock_i,
    output logic                           pll_sclk_o,
    output logic                           pll_sdin_o,
    output logic                           pll_load_o,
    output logic                           busy_o,
    output logic                           init_done_o,
    output logic                           init_fail_o,
    output logic [RW-1:0]                  retry_count_o
);

    // state      | meaning
    // IDLE       | waiting for a start or skip request
    // LOAD       | word[idx] placed in the shift register, MSB on sdin
    // CLK_HIGH   | sclk high, external PLL samples sdin
    // CLK_LOW    | sclk low, next bit presented
    // LE         | latch-enable pulse for the finished word
    // WAIT       | inter-word delay
    // LOCK_WAIT  | waiting for synchronised lock, with timeout
    // DONE       | configuration complete
    // FAIL       | retries exhausted, waiting for a new init

    localparam int WAIT_T = (SIM_SPDUP == "TRUE") ? 10 : WAIT_TICKS;
    localparam int LOCK_T = (SIM_SPDUP == "TRUE") ? 20 : LOCK_TIMEOUT;
    localparam int TMAX   = (WAIT_T > LOCK_T) ? WAIT_T : LOCK_T;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW     = $clog2(WORD_BITS + 1);
    localparam int IW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_WORDS - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(WAIT_T - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_T - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLK_HIGH,
        ST_CLK_LOW,
        ST_LE,
        ST_WAIT,
        ST_LOCK_WAIT,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic                 tick;
    logic                 init_flag_q, init_flag_d;
    logic                 skip_flag_q, skip_flag_d;
    logic                 lock_meta_q, lock_sync_q;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic                 sclk_d, sdin_d, load_d, busy_d, done_d, fail_d;
    logic [WORD_BITS-1:0] word_tbl [NUM_WORDS];

`ifdef TOF_SERIAL_CFG_RELOCK_EN
    logic                 relock_arm_q, relock_arm_d;
    logic [1:0]           relock_cnt_q, relock_cnt_d;
`endif

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word_tbl
        assign word_tbl[k] = words_i[k*WORD_BITS +: WORD_BITS];
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        retry_d     = retry_q;
        init_flag_d = init_flag_q | init_i;
        skip_flag_d = skip_flag_q | init_skip_i;
`ifdef TOF_SERIAL_CFG_RELOCK_EN
        relock_arm_d = relock_arm_q;
        relock_cnt_d = relock_cnt_q;
`endif
        if (tick) begin
            // pending requests are consumed in IDLE/FAIL and discarded anywhere else
            init_flag_d = init_i;
            skip_flag_d = init_skip_i;
            case (state_q)
                ST_IDLE: begin
                    if (init_flag_q) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                        retry_d = '0;
                    end else if (skip_flag_q) begin
                        state_d = ST_DONE;
                    end
                end
                ST_LOAD: begin
                    bitcnt_d = '0;
                    state_d  = ST_CLK_HIGH;
                end
                ST_CLK_HIGH: begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    shreg_d  = {shreg_q[WORD_BITS-2:0], 1'b0};
                    state_d  = ST_CLK_LOW;
                end
                ST_CLK_LOW: begin
                    state_d = (bitcnt_q == BIT_LAST) ? ST_LE : ST_CLK_HIGH;
                end
                ST_LE: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_LOCK_WAIT;
                        tmr_d   = LOCK_LOAD;
                    end else if (wait_mask_i[idx_q]) begin
                        state_d = ST_WAIT;
                        tmr_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (tmr_q == '0) begin
                        state_d = ST_LOAD;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_LOCK_WAIT: begin
                    if (lock_sync_q) begin
                        state_d = ST_DONE;
`ifdef TOF_SERIAL_CFG_RELOCK_EN
                        relock_arm_d = 1'b1;
                        relock_cnt_d = 2'd3;
`endif
                    end else if (tmr_q == '0) begin
                        if (retry_q != RETRY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            idx_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef TOF_SERIAL_CFG_RELOCK_EN
                    if (relock_arm_q && !lock_sync_q) begin
                        if (relock_cnt_q == 2'd0) begin
                            state_d      = ST_LOAD;
                            idx_d        = '0;
                            retry_d      = '0;
                            relock_arm_d = 1'b0;
                        end else begin
                            relock_cnt_d = relock_cnt_q - 1'b1;
                        end
                    end else begin
                        relock_cnt_d = 2'd3;
                    end
`endif
                end
                ST_FAIL: begin
                    if (init_flag_q) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                        retry_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_d == ST_LOAD) begin
                shreg_d = word_tbl[idx_d];
            end
        end
    end

    // outputs decode the next state so they register in step with state_q
    always_comb begin
        sclk_d = (state_d == ST_CLK_HIGH);
        load_d = (state_d == ST_LE);
        sdin_d = ((state_d == ST_LOAD) || (state_d == ST_CLK_HIGH) || (state_d == ST_CLK_LOW))
                 ? shreg_d[WORD_BITS-1] : 1'b0;
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
        done_d = (state_d == ST_DONE);
        fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            init_flag_q   <= 1'b0;
            skip_flag_q   <= 1'b0;
            lock_meta_q   <= 1'b0;
            lock_sync_q   <= 1'b0;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            idx_q         <= '0;
            tmr_q         <= '0;
            retry_q       <= '0;
            pll_sclk_o    <= 1'b0;
            pll_sdin_o    <= 1'b0;
            pll_load_o    <= 1'b0;
            busy_o        <= 1'b0;
            init_done_o   <= 1'b0;
            init_fail_o   <= 1'b0;
            retry_count_o <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            init_flag_q   <= init_flag_d;
            skip_flag_q   <= skip_flag_d;
            lock_meta_q   <= pll_lock_i;
            lock_sync_q   <= lock_meta_q;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            idx_q         <= idx_d;
            tmr_q         <= tmr_d;
            retry_q       <= retry_d;
            pll_sclk_o    <= sclk_d;
            pll_sdin_o    <= sdin_d;
            pll_load_o    <= load_d;
            busy_o        <= busy_d;
            init_done_o   <= done_d;
            init_fail_o   <= fail_d;
            retry_count_o <= retry_d;
        end
    end

`ifdef TOF_SERIAL_CFG_RELOCK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            relock_arm_q <= 1'b0;
            relock_cnt_q <= 2'd3;
        end else begin
            relock_arm_q <= relock_arm_d;
            relock_cnt_q <= relock_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_tof_serial_cfg_loader.sv
// Self-checking bench for tof_serial_cfg_loader: serial bits scoreboarded on every sclk rise.
module tb_tof_serial_cfg_loader;

    localparam int WB = 24;
    localparam int NW = 3;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             init_i = 1'b0;
    logic             init_skip_i = 1'b0;
    logic [NW*WB-1:0] words_i;
    logic [NW-1:0]    wait_mask_i = 3'b010;
    logic             pll_lock_i = 1'b0;
    logic             pll_sclk_o, pll_sdin_o, pll_load_o;
    logic             busy_o, init_done_o, init_fail_o;
    logic [1:0]       retry_count_o;

    tof_serial_cfg_loader #(
        .WORD_BITS(WB), .NUM_WORDS(NW), .CLK_DIV(4), .MAX_RETRY(2), .SIM_SPDUP("TRUE")
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .init_i(init_i), .init_skip_i(init_skip_i),
        .words_i(words_i), .wait_mask_i(wait_mask_i), .pll_lock_i(pll_lock_i),
        .pll_sclk_o(pll_sclk_o), .pll_sdin_o(pll_sdin_o), .pll_load_o(pll_load_o),
        .busy_o(busy_o), .init_done_o(init_done_o), .init_fail_o(init_fail_o),
        .retry_count_o(retry_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int sclk_rises = 0;
    int load_rises = 0;
    int load_rise_cyc = 0;
    int le_fall_cyc = 0;
    bit gap_pend = 0;
    bit sclk_p = 0;
    bit load_p = 0;
    bit exp_bits[$];
    int gaps[$];
    int widths[$];

    // monitor: pops one expected bit per sclk rise, records LE widths and LE-to-next-rise gaps
    always @(negedge clk_i) begin
        bit e;
        cyc++;
        if (pll_sclk_o && !sclk_p) begin
            sclk_rises++;
            if (gap_pend) begin
                gaps.push_back(cyc - le_fall_cyc);
                gap_pend = 0;
            end
            n_total++;
            if (exp_bits.size() == 0) begin
                $display("FAIL sdin_bit: sclk rise #%0d with sdin=%b but no bit expected", sclk_rises, pll_sdin_o);
            end else begin
                e = exp_bits.pop_front();
                if (pll_sdin_o !== e)
                    $display("FAIL sdin_bit: rise #%0d got %b expected %b", sclk_rises, pll_sdin_o, e);
                else
                    n_pass++;
            end
        end
        if (pll_load_o && !load_p) begin
            load_rises++;
            load_rise_cyc = cyc;
        end
        if (!pll_load_o && load_p) begin
            widths.push_back(cyc - load_rise_cyc);
            le_fall_cyc = cyc;
            gap_pend = 1;
        end
        sclk_p = pll_sclk_o;
        load_p = pll_load_o;
    end

    task automatic push_seq();
        for (int k = 0; k < NW; k++)
            for (int b = WB - 1; b >= 0; b--)
                exp_bits.push_back(words_i[k*WB + b]);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        init_i = 1'b0;
        init_skip_i = 1'b0;
        repeat (3) @(negedge clk_i);
        exp_bits.delete();
        gaps.delete();
        widths.delete();
        gap_pend = 0;
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic pulse_init(input bit ini, input bit skp);
        @(negedge clk_i);
        init_i = ini;
        init_skip_i = skp;
        @(negedge clk_i);
        init_i = 1'b0;
        init_skip_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        got = {pll_sclk_o, pll_sdin_o, pll_load_o, busy_o, init_done_o, init_fail_o, retry_count_o};
        n_total++;
        if (got !== 8'h00) $display("FAIL reset_outputs: got %h expected 00", got); else n_pass++;
        rst_n_i = 1'b1;
        repeat (20) @(negedge clk_i);
        got = {pll_sclk_o, pll_sdin_o, pll_load_o, busy_o, init_done_o, init_fail_o, retry_count_o};
        n_total++;
        if (got !== 8'h00) $display("FAIL idle_outputs: got %h expected 00", got); else n_pass++;
    endtask

    task automatic test_base();
        int s0, l0, t_done;
        do_reset();
        pll_lock_i = 1'b1;
        push_seq();
        s0 = sclk_rises; l0 = load_rises;
        pulse_init(1'b1, 1'b0);
        for (int i = 0; i < 3000 && !init_done_o; i++) @(negedge clk_i);
        t_done = cyc;
        n_total++;
        if (init_done_o !== 1'b1) $display("FAIL base_done: got %b expected 1", init_done_o); else n_pass++;
        n_total++;
        if (sclk_rises - s0 != 72) $display("FAIL base_sclk_rises: got %0d expected 72", sclk_rises - s0); else n_pass++;
        n_total++;
        if (load_rises - l0 != 3) $display("FAIL base_load_pulses: got %0d expected 3", load_rises - l0); else n_pass++;
        n_total++;
        if (widths.size() != 3 || widths[0] != 4 || widths[1] != 4 || widths[2] != 4)
            $display("FAIL base_load_width: got %0d pulses, first width %0d expected 3 of 4", widths.size(),
                     (widths.size() > 0) ? widths[0] : -1);
        else n_pass++;
        n_total++;
        if (gaps.size() < 2 || gaps[0] != 4) $display("FAIL base_gap_nowait: got %0d expected 4",
                                                       (gaps.size() > 0) ? gaps[0] : -1);
        else n_pass++;
        n_total++;
        if (gaps.size() < 2 || gaps[1] != 44) $display("FAIL base_gap_wait: got %0d expected 44",
                                                        (gaps.size() > 1) ? gaps[1] : -1);
        else n_pass++;
        n_total++;
        if (t_done - le_fall_cyc < 1 || t_done - le_fall_cyc > 8)
            $display("FAIL base_done_latency: got %0d expected 1..8 cycles", t_done - le_fall_cyc);
        else n_pass++;
        n_total++;
        if ({busy_o, init_fail_o, retry_count_o} !== 4'h0)
            $display("FAIL base_status: got %b expected 0000", {busy_o, init_fail_o, retry_count_o});
        else n_pass++;
    endtask

    task automatic test_skip();
        int s0, l0, t0;
        do_reset();
        pll_lock_i = 1'b0;
        s0 = sclk_rises; l0 = load_rises;
        pulse_init(1'b0, 1'b1);
        t0 = cyc;
        for (int i = 0; i < 20 && !init_done_o; i++) @(negedge clk_i);
        n_total++;
        if (init_done_o !== 1'b1 || cyc - t0 > 8)
            $display("FAIL skip_done: got done=%b after %0d cycles expected 1 within 8", init_done_o, cyc - t0);
        else n_pass++;
        repeat (100) @(negedge clk_i);
        n_total++;
        if (sclk_rises != s0 || load_rises != l0)
            $display("FAIL skip_no_edges: got %0d sclk %0d load expected 0 0", sclk_rises - s0, load_rises - l0);
        else n_pass++;
        n_total++;
        if (init_done_o !== 1'b1) $display("FAIL skip_done_held: got %b expected 1", init_done_o); else n_pass++;
    endtask

    task automatic test_timeout();
        int s0;
        do_reset();
        pll_lock_i = 1'b0;
        push_seq(); push_seq(); push_seq();
        s0 = sclk_rises;
        pulse_init(1'b1, 1'b0);
        for (int i = 0; i < 5000 && !init_fail_o; i++) @(negedge clk_i);
        n_total++;
        if (init_fail_o !== 1'b1) $display("FAIL timeout_fail: got %b expected 1", init_fail_o); else n_pass++;
        n_total++;
        if (sclk_rises - s0 != 216) $display("FAIL timeout_sclk_rises: got %0d expected 216", sclk_rises - s0);
        else n_pass++;
        n_total++;
        if (retry_count_o !== 2'd2) $display("FAIL timeout_retry: got %0d expected 2", retry_count_o); else n_pass++;
        n_total++;
        if ({init_done_o, busy_o} !== 2'b00) $display("FAIL timeout_status: got %b expected 00", {init_done_o, busy_o});
        else n_pass++;
        pll_lock_i = 1'b1;
        push_seq();
        s0 = sclk_rises;
        pulse_init(1'b1, 1'b0);
        for (int i = 0; i < 3000 && !init_done_o; i++) @(negedge clk_i);
        n_total++;
        if (init_done_o !== 1'b1) $display("FAIL recover_done: got %b expected 1", init_done_o); else n_pass++;
        n_total++;
        if (sclk_rises - s0 != 72) $display("FAIL recover_sclk_rises: got %0d expected 72", sclk_rises - s0);
        else n_pass++;
        n_total++;
        if ({init_fail_o, retry_count_o} !== 3'b000)
            $display("FAIL recover_status: got %b expected 000", {init_fail_o, retry_count_o});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s0, l0;
        logic [7:0] got;
        do_reset();
        pll_lock_i = 1'b1;
        push_seq();
        s0 = sclk_rises;
        pulse_init(1'b1, 1'b0);
        for (int i = 0; i < 500 && (sclk_rises - s0) < 10; i++) @(negedge clk_i);
        n_total++;
        if (sclk_rises - s0 < 10) $display("FAIL midreset_reach: got %0d rises expected 10", sclk_rises - s0);
        else n_pass++;
        rst_n_i = 1'b0;
        #1;
        got = {pll_sclk_o, pll_sdin_o, pll_load_o, busy_o, init_done_o, init_fail_o, retry_count_o};
        n_total++;
        if (got !== 8'h00) $display("FAIL midreset_outputs: got %h expected 00", got); else n_pass++;
        exp_bits.delete();
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        s0 = sclk_rises; l0 = load_rises;
        repeat (200) @(negedge clk_i);
        n_total++;
        if (sclk_rises != s0 || load_rises != l0 || busy_o !== 1'b0)
            $display("FAIL midreset_quiet: got %0d sclk %0d load busy=%b expected 0 0 0",
                     sclk_rises - s0, load_rises - l0, busy_o);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int s0, l0;
        do_reset();
        pll_lock_i = 1'b0;
        push_seq();
        s0 = sclk_rises; l0 = load_rises;
        pulse_init(1'b1, 1'b1);
        for (int i = 0; i < 3000 && (load_rises - l0) < 3; i++) @(negedge clk_i);
        repeat (40) @(negedge clk_i);
        n_total++;
        if (sclk_rises - s0 != 72) $display("FAIL simul_sclk_rises: got %0d expected 72", sclk_rises - s0);
        else n_pass++;
        n_total++;
        if ({init_done_o, busy_o} !== 2'b01)
            $display("FAIL simul_lock_wait: got done,busy=%b expected 01", {init_done_o, busy_o});
        else n_pass++;
        pll_lock_i = 1'b1;
        for (int i = 0; i < 40 && !init_done_o; i++) @(negedge clk_i);
        n_total++;
        if (init_done_o !== 1'b1) $display("FAIL simul_done: got %b expected 1", init_done_o); else n_pass++;
    endtask

    task automatic test_relock();
        int s0;
        s0 = sclk_rises;
`ifdef TOF_SERIAL_CFG_RELOCK_EN
        push_seq();
        pll_lock_i = 1'b0;
        for (int i = 0; i < 100 && init_done_o; i++) @(negedge clk_i);
        n_total++;
        if (init_done_o !== 1'b0) $display("FAIL relock_drop: got %b expected 0", init_done_o); else n_pass++;
        pll_lock_i = 1'b1;
        for (int i = 0; i < 3000 && !init_done_o; i++) @(negedge clk_i);
        n_total++;
        if (init_done_o !== 1'b1 || sclk_rises - s0 != 72)
            $display("FAIL relock_restart: got done=%b rises=%0d expected 1 72", init_done_o, sclk_rises - s0);
        else n_pass++;
`else
        pll_lock_i = 1'b0;
        repeat (100) @(negedge clk_i);
        n_total++;
        if (init_done_o !== 1'b1 || sclk_rises != s0)
            $display("FAIL relock_ignored: got done=%b rises=%0d expected 1 0", init_done_o, sclk_rises - s0);
        else n_pass++;
`endif
    endtask

    initial begin
        words_i = {24'h002C0A, 24'h0481A4, 24'h34002D};
        test_reset();
        test_base();
        test_skip();
        test_timeout();
        test_reset_mid();
        test_simultaneous();
        test_relock();
        n_total++;
        if (exp_bits.size() != 0) $display("FAIL leftover_bits: got %0d expected 0", exp_bits.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
